// File: rtl/decoder_pkg.sv
// decoder_pkg: shared opcode, cmd, ALU-control and immediate-source encodings
package decoder_pkg;
  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } opE;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
endpackage

// File: rtl/decoder_if.sv
// decoder_if: instruction fields in, registered datapath controls out
interface decoder_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       MemtoReg;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  modport master (
    output Op, Funct, Rd,
    input  FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl
  );
  modport slave (
    input  Op, Funct, Rd,
    output FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/decoder_alu_dec.sv
// decoder_alu_dec: combinational ALU-control and flag-write decode
module decoder_alu_dec
  import decoder_pkg::*;
(
  input  logic       aluOp,
  input  logic [4:0] funct,
  output logic [1:0] aluControl,
  output logic [1:0] flagW
);
  logic [3:0] cmd;
  logic       s, supported, arith;
  always_comb begin
    cmd        = funct[4:1];
    s          = funct[0];
    arith      = (cmd == CMD_ADD) || (cmd == CMD_SUB);
    supported  = arith || (cmd == CMD_AND) || (cmd == CMD_ORR);
    aluControl = !aluOp            ? ALU_ADD :
                 (cmd == CMD_SUB)  ? ALU_SUB :
                 (cmd == CMD_AND)  ? ALU_AND :
                 (cmd == CMD_ORR)  ? ALU_ORR : ALU_ADD;
    flagW      = {aluOp & supported & s, aluOp & arith & s};
  end
endmodule

// File: rtl/decoder.sv
// decoder: main control decode with registered outputs for the ARM-subset core
module decoder
  import decoder_pkg::*;
(
  input logic      clk,
  input logic      reset,
  decoder_if.slave bus
);
  logic       branch, aluOp, regW, memW, memtoReg, aluSrc, pcs;
  logic [1:0] immSrc, regSrc, aluControl, flagW;
  decoder_alu_dec aluDec (
    .aluOp      (aluOp),
    .funct      (bus.Funct[4:0]),
    .aluControl (aluControl),
    .flagW      (flagW)
  );
  always_comb begin
    branch   = 1'b0;
    aluOp    = 1'b0;
    regW     = 1'b0;
    memW     = 1'b0;
    memtoReg = 1'b0;
    aluSrc   = 1'b0;
    immSrc   = IMM_DP;
    regSrc   = 2'b00;
    case (opE'(bus.Op))
      OP_DP: begin
        regW   = 1'b1;
        aluSrc = bus.Funct[5];
        aluOp  = 1'b1;
      end
      OP_MEM: begin
        regW     = bus.Funct[0];
        memW     = ~bus.Funct[0];
        memtoReg = bus.Funct[0];
        aluSrc   = 1'b1;
        immSrc   = IMM_MEM;
        regSrc   = bus.Funct[0] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        branch = 1'b1;
        aluSrc = 1'b1;
        immSrc = IMM_BR;
        regSrc = 2'b01;
      end
      default: ;
    endcase
    pcs = branch | (regW & (bus.Rd == 4'hF));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.FlagW      <= '0;
      bus.PCS        <= 1'b0;
      bus.RegW       <= 1'b0;
      bus.MemW       <= 1'b0;
      bus.MemtoReg   <= 1'b0;
      bus.ALUSrc     <= 1'b0;
      bus.ImmSrc     <= '0;
      bus.RegSrc     <= '0;
      bus.ALUControl <= '0;
    end else begin
      bus.FlagW      <= flagW;
      bus.PCS        <= pcs;
      bus.RegW       <= regW;
      bus.MemW       <= memW;
      bus.MemtoReg   <= memtoReg;
      bus.ALUSrc     <= aluSrc;
      bus.ImmSrc     <= immSrc;
      bus.RegSrc     <= regSrc;
      bus.ALUControl <= aluControl;
    end
  end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed vectors against hand-computed control words
module tb_decoder;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [12:0] got;
  decoder_if dif ();
  decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );
  always #5 clk = ~clk;
  // control word: {FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl}
  assign got = {dif.FlagW, dif.PCS, dif.RegW, dif.MemW, dif.MemtoReg, dif.ALUSrc,
                dif.ImmSrc, dif.RegSrc, dif.ALUControl};
  task automatic check(input string tag, input logic [12:0] actual, input logic [12:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask
  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    dif.Op = op;
    dif.Funct = funct;
    dif.Rd = rd;
  endtask
  task automatic step(input string tag, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rd, input logic [12:0] expected);
    drive(op, funct, rd);
    @(posedge clk);
    #1;
    check(tag, got, expected);
  endtask
  initial begin
    reset = 1'b1;
    drive(2'b00, 6'b000000, 4'h0);
    @(posedge clk); #1; check("reset1", got, 13'b0);
    @(posedge clk); #1; check("reset2", got, 13'b0);
    reset = 1'b0;
    step("and_reg",   2'b00, 6'b000000, 4'h0, 13'b00_0_1_0_0_0_00_00_10);
    drive(2'b01, 6'b000000, 4'h0);
    @(negedge clk);
    check("hold", got, 13'b00_0_1_0_0_0_00_00_10);
    @(posedge clk); #1;
    check("str",      got, 13'b00_0_0_1_0_1_01_10_00);
    step("ldr",       2'b01, 6'b000001, 4'h0, 13'b00_0_1_0_1_1_01_00_00);
    step("ldr_pc",    2'b01, 6'b000001, 4'hF, 13'b00_1_1_0_1_1_01_00_00);
    step("str_rdF",   2'b01, 6'b111110, 4'hF, 13'b00_0_0_1_0_1_01_10_00);
    step("b",         2'b10, 6'b000000, 4'hF, 13'b00_1_0_0_0_1_10_01_00);
    reset = 1'b1;
    step("reset_mid", 2'b10, 6'b000000, 4'hF, 13'b0);
    reset = 1'b0;
    step("b_any",     2'b10, 6'b111111, 4'h0, 13'b00_1_0_0_0_1_10_01_00);
    step("unsup",     2'b00, 6'b010000, 4'h1, 13'b00_0_1_0_0_0_00_00_00);
    step("unsup_s",   2'b00, 6'b010001, 4'h1, 13'b00_0_1_0_0_0_00_00_00);
    step("adds_pc",   2'b00, 6'b101001, 4'hF, 13'b11_1_1_0_0_1_00_00_00);
    step("subs",      2'b00, 6'b000101, 4'h2, 13'b11_0_1_0_0_0_00_00_01);
    step("sub_nos",   2'b00, 6'b000100, 4'h2, 13'b00_0_1_0_0_0_00_00_01);
    step("orrs_imm",  2'b00, 6'b111001, 4'h3, 13'b10_0_1_0_0_1_00_00_11);
    step("ands",      2'b00, 6'b000001, 4'h4, 13'b10_0_1_0_0_0_00_00_10);
    step("and_pc",    2'b00, 6'b000000, 4'hF, 13'b00_1_1_0_0_0_00_00_10);
    step("und_ff",    2'b11, 6'b111111, 4'hF, 13'b0);
    step("und_00",    2'b11, 6'b000000, 4'h0, 13'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
